// File: rtl/fifo_rd_stage.sv
// rtl/fifo_rd_stage.sv - FWFT valid/ready read stage with 2-entry output buffer
// Optional transfer counter compiled in by defining FIFO_RD_STAGE_XFER_CNT_EN
module fifo_rd_stage #(
  parameter int DSIZE = 8
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  output logic [DSIZE-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready
`ifdef FIFO_RD_STAGE_XFER_CNT_EN
  ,
  output logic [15:0]      xfer_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             inflight_q, inflight_d;
  logic [DSIZE-1:0] head_q, head_d;
  logic [DSIZE-1:0] tail_q, tail_d;
  logic             pop;
  logic             capture;
  logic [1:0]       occ;

  // Head entry is always the older word; tail only used in TWO.
  assign dout_valid = (state_q != ST_EMPTY);
  assign dout       = head_q;
  assign pop        = dout_valid & dout_ready;
  assign capture    = inflight_q;

  // Read request: only when the words already owned (buffered + in flight)
  // minus this cycle's pop leave room, so a capture in TWO cannot happen.
  always_comb begin
    occ = 2'd0;
    case (state_q)
      ST_ONE:  occ = 2'd1;
      ST_TWO:  occ = 2'd2;
      default: occ = 2'd0;
    endcase
    rinc = rrst_n & ~rempty &
           (({1'b0, occ} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));
    inflight_d = rinc;
  end

  // Occupancy FSM and buffer data movement.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      ST_EMPTY: begin
        if (capture) begin
          head_d  = rdata;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (capture && pop) begin
          head_d = rdata;
        end else if (capture) begin
          tail_d  = rdata;
          state_d = ST_TWO;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (pop) begin
          head_d  = tail_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // State, in-flight flag and buffer registers; reset drops everything held.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q    <= ST_EMPTY;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

`ifdef FIFO_RD_STAGE_XFER_CNT_EN
  logic [15:0] xfer_cnt_q, xfer_cnt_d;

  // Delivered-word count, wraps naturally at 16 bits.
  always_comb begin
    xfer_cnt_d = xfer_cnt_q + {15'd0, pop};
  end

  // Transfer counter register.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      xfer_cnt_q <= 16'd0;
    end else begin
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  assign xfer_cnt = xfer_cnt_q;
`endif

endmodule

// File: doc/fifo_rd_stage.md
FIFO_RD_STAGE -- requirements
Module: fifo_rd_stage

Interface
REQ-001 SHALL have parameter DSIZE, default 8, data width in bits.
REQ-002 SHALL have port rclk  input  1  read-domain clock; all logic on its rising edge.
REQ-003 SHALL have port rrst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port rempty  input  1  FIFO empty flag from the read-pointer/empty stage.
REQ-005 SHALL have port rdata  input  DSIZE  FIFO memory read data, valid exactly one rclk after an accepted rinc.
REQ-006 SHALL have port rinc  output  1  read request to the read-pointer/empty stage.
REQ-007 SHALL have port dout  output  DSIZE  head-of-stream data.
REQ-008 SHALL have port dout_valid  output  1  dout holds a valid word.
REQ-009 SHALL have port dout_ready  input  1  consumer accepts dout this cycle.
REQ-010 SHALL have port xfer_cnt  output  16  words delivered; present only per REQ-030.

Function
REQ-011 SHALL convert the FIFO read port into a first-word-fall-through valid/ready stream with a 2-entry output buffer.
REQ-012 SHALL treat a read as issued when rinc=1 and rempty=0, and SHALL hold a 1-bit in-flight flag set for the following cycle.
REQ-013 SHALL capture rdata into the buffer in the cycle the in-flight flag is 1.
REQ-014 SHALL define pop = dout_valid & dout_ready, with dout and dout_valid stable until pop.
REQ-015 SHALL drive rinc = ~rempty & (occupancy + inflight - pop < 2); rinc is never 1 while rempty=1.
REQ-016 SHALL implement buffer occupancy as FSM EMPTY/ONE/TWO: EMPTY->ONE on capture; ONE->TWO on capture without pop; ONE->EMPTY on pop without capture; TWO->ONE on pop; other cases hold.
REQ-017 SHALL, on simultaneous capture and pop in ONE, present the captured word next cycle and stay in ONE.
REQ-018 SHALL, on capture while EMPTY, assert dout_valid the next cycle with dout = captured word.
REQ-019 SHALL preserve word order; the older word is always at dout.
REQ-020 SHALL sustain one word per cycle when rempty=0 and dout_ready=1 continuously.
REQ-021 SHALL never overflow: capture in TWO without pop is impossible by REQ-015.
REQ-022 SHALL have first-word latency of 2 rclk from rempty falling (rinc in cycle 0, capture in cycle 1, dout_valid in cycle 2).
REQ-023 SHALL not react to rempty changes for an already-issued read; in-flight data is always captured.
REQ-024 SHALL keep dout_valid=1 in TWO regardless of rempty.

Reset
REQ-025 SHALL, on rrst_n=0, asynchronously force state EMPTY, inflight=0, dout_valid=0, dout=0, xfer_cnt=0.
REQ-026 SHALL drive rinc=0 during reset.
REQ-027 SHALL discard buffered and in-flight words on reset mid-operation; the FIFO pointers are reset by the same rrst_n.
REQ-028 SHALL resume normal operation on the first rclk edge after rrst_n deasserts.

Configuration
REQ-029 SHALL use macro FIFO_RD_STAGE_XFER_CNT_EN to compile in the transfer counter.
REQ-030 SHALL, with the macro defined, increment xfer_cnt by 1 on each pop and wrap 0xFFFF->0x0000; without it, SHALL omit the xfer_cnt port and counter; all other behaviour identical.

Verification
REQ-031 SHALL cover first word: after reset, rempty 1->0 with rdata=0xA5 following rinc, dout_ready=0 -> rinc in cycle 0, dout_valid=1 and dout=0xA5 in cycle 2, exactly two reads issued, then rinc=0.
REQ-032 SHALL cover streaming: FIFO holding 0x01..0x10, dout_ready=1 -> 16 consecutive pops of 0x01..0x10 in order, one per cycle after the first.
REQ-033 SHALL cover backpressure: TWO with 0x11,0x22, dout_ready=0 for 5 cycles -> dout=0x11 held, rinc=0; then dout_ready=1 -> 0x11, 0x22 delivered on consecutive cycles.
REQ-034 SHALL cover drain: FIFO with 3 words, rempty rising after the third read -> exactly 3 pops, then dout_valid=0, rinc=0.
REQ-035 SHALL cover reset mid-stream: rrst_n=0 in TWO with a read in flight -> dout_valid=0, rinc=0, xfer_cnt=0 immediately, no stale word after release.
REQ-036 SHALL cover counter wrap with FIFO_RD_STAGE_XFER_CNT_EN: 65537 pops -> xfer_cnt=0x0001.
